cmd_dispatch: RTL

//  Host-side end of the unit command bus: parses 32-bit command frames, buffers all args, issues the command to one

---
 rtl/cmd_dispatch.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cmd_dispatch.sv
// Host-side end of the unit command bus: parses command frames, issues one command at a time to a unit,
// collects its parameter writes into a response frame, and grants involuntary report slots when idle.
module cmd_dispatch #(
  parameter int unsigned NUNITS   = 8,
  parameter int unsigned CMD_BITS = 8,
  parameter int unsigned MAX_ARGS = 8,
  parameter int unsigned RESP_MAX = 16,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CMD_BITS-1:0]  cmd,
  output logic [NUNITS-1:0]    cmd_ready,
  output logic [31:0]          arg_data,
  input  logic [NUNITS-1:0]    arg_advance,
  input  logic [NUNITS-1:0]    cmd_done,
  input  logic [NUNITS*32-1:0] param_data,
  input  logic [NUNITS-1:0]    param_write,
  input  logic [NUNITS-1:0]    invol_req,
  output logic [NUNITS-1:0]    invol_grant
);
  localparam int unsigned UW  = (NUNITS > 1) ? $clog2(NUNITS) : 1;
  localparam int unsigned AW  = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;
  localparam int unsigned RIW = (RESP_MAX > 1) ? $clog2(RESP_MAX) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_ERR   = 8'h01;
  localparam logic [7:0] ST_TMO   = 8'h02;
  localparam logic [7:0] ST_OVF   = 8'h03;
  localparam logic [7:0] ST_INVOL = 8'h80;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ARGS, S_ISSUE, S_EXEC, S_REPLY} state_e;

  state_e          state_q, state_d;
  logic [7:0]      unit_q, unit_d, hcmd_q, hcmd_d, nargs_q, nargs_d, argc_q, argc_d;
  logic [7:0]      rd_q, rd_d, cnt_q, cnt_d, ridx_q, ridx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d, ovf_q, ovf_d, tflag_q, tflag_d, invol_q, invol_d;
  logic [UW-1:0]   rr_q, rr_d;

  logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [31:0]         out_data_q, out_data_d, arg_data_q, arg_data_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [NUNITS-1:0]   cmd_ready_q, cmd_ready_d, invol_grant_q, invol_grant_d;

  logic [31:0] arg_buf_q  [MAX_ARGS];
  logic [31:0] resp_buf_q [RESP_MAX];

  logic [UW-1:0]     sel, pick_idx, scan_idx;
  logic              pick_ok, arg_we, resp_we, busy_d;
  logic [31:0]       resp_wdata, arg_word;
  logic [7:0]        status;
  logic [NUNITS-1:0] onehot_d;

  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign cmd         = cmd_q;
  assign cmd_ready   = cmd_ready_q;
  assign arg_data    = arg_data_q;
  assign invol_grant = invol_grant_q;

  always_comb begin
    state_d = state_q;  unit_d = unit_q;  hcmd_d = hcmd_q;  nargs_d = nargs_q;
    argc_d  = argc_q;   rd_d   = rd_q;    cnt_d  = cnt_q;   ridx_d  = ridx_q;
    tmo_d   = tmo_q;    err_d  = err_q;   ovf_d  = ovf_q;   tflag_d = tflag_q;
    invol_d = invol_q;  rr_d   = rr_q;
    arg_we  = 1'b0;
    resp_we = 1'b0;
    sel        = unit_q[UW-1:0];
    resp_wdata = param_data[32*sel +: 32];

    // Round-robin scan of involuntary requests starting at rr_q
    pick_ok  = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < int'(NUNITS); i++) begin
      scan_idx = UW'((int'(rr_q) + i) % int'(NUNITS));
      if (!pick_ok && invol_req[scan_idx]) begin
        pick_ok  = 1'b1;
        pick_idx = scan_idx;
      end
    end

    if (state_q == S_ISSUE || state_q == S_EXEC) begin
      if (param_write[sel]) begin
        if (cnt_q < 8'(RESP_MAX)) begin
          resp_we = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (arg_advance[sel] && rd_q < nargs_q) rd_d = rd_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_HDR;
        end else if (pick_ok) begin
          state_d = S_EXEC;  invol_d = 1'b1;  unit_d = 8'(pick_idx);  hcmd_d = '0;
          nargs_d = '0;  rd_d = '0;  cnt_d = '0;  ridx_d = '0;  tmo_d = '0;
          err_d = 1'b0;  ovf_d = 1'b0;  tflag_d = 1'b0;
        end
      end
      S_HDR: begin
        if (in_valid) begin
          unit_d  = in_data[31:24];  hcmd_d = in_data[23:16];  nargs_d = in_data[7:0];
          argc_d  = '0;  rd_d = '0;  cnt_d = '0;  ridx_d = '0;  tmo_d = '0;
          ovf_d   = 1'b0;  tflag_d = 1'b0;  invol_d = 1'b0;
          err_d   = (in_data[31:24] >= 8'(NUNITS)) || (in_data[7:0] > 8'(MAX_ARGS));
          if (in_data[7:0] != 8'd0) state_d = S_ARGS;
          else                      state_d = err_d ? S_REPLY : S_ISSUE;
        end
      end
      S_ARGS: begin
        // Malformed frames are drained without touching the arg buffer
        if (in_valid) begin
          arg_we = !err_q;
          argc_d = argc_q + 8'd1;
          if (argc_d == nargs_q) state_d = err_q ? S_REPLY : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        if (cmd_done[sel]) begin
          state_d = S_REPLY;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_REPLY;
          tflag_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
        if (state_d == S_REPLY && invol_q) rr_d = UW'((int'(sel) + 1) % int'(NUNITS));
      end
      S_REPLY: begin
        if (out_valid_q && out_ready) begin
          if (ridx_q == cnt_q) state_d = S_IDLE;
          else                 ridx_d  = ridx_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from next-state values
    busy_d        = (state_d == S_ISSUE) || (state_d == S_EXEC);
    onehot_d      = NUNITS'(1) << unit_d[UW-1:0];
    in_ready_d    = (state_d == S_HDR) || (state_d == S_ARGS);
    cmd_ready_d   = (state_d == S_ISSUE) ? onehot_d : '0;
    invol_grant_d = (state_d == S_EXEC && invol_d) ? onehot_d : '0;
    cmd_d         = (busy_d && !invol_d) ? CMD_BITS'(hcmd_d) : '0;

    // Bypass covers the last arg being written in the same cycle it is first presented
    arg_word = arg_buf_q[AW'(rd_d)];
    if (arg_we && AW'(argc_q) == AW'(rd_d)) arg_word = in_data;
    arg_data_d = (busy_d && rd_d < nargs_d) ? arg_word : '0;

    status = err_d ? ST_ERR : tflag_d ? ST_TMO : ovf_d ? ST_OVF : ST_OK;
    if (invol_d) status = status | ST_INVOL;
    out_valid_d = (state_d == S_REPLY);
    out_data_d  = '0;
    if (state_d == S_REPLY) begin
      out_data_d = (ridx_d == 8'd0) ? {unit_d, hcmd_d, status, cnt_d}
                                    : resp_buf_q[RIW'(ridx_d - 8'd1)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  unit_q <= '0;  hcmd_q <= '0;  nargs_q <= '0;  argc_q <= '0;
      rd_q    <= '0;      cnt_q  <= '0;  ridx_q <= '0;  tmo_q   <= '0;
      err_q   <= 1'b0;    ovf_q  <= 1'b0;  tflag_q <= 1'b0;  invol_q <= 1'b0;  rr_q <= '0;
      in_ready_q <= 1'b0;  out_valid_q <= 1'b0;  out_data_q <= '0;  arg_data_q <= '0;
      cmd_q      <= '0;    cmd_ready_q <= '0;    invol_grant_q <= '0;
    end else begin
      state_q <= state_d;  unit_q <= unit_d;  hcmd_q <= hcmd_d;  nargs_q <= nargs_d;
      argc_q  <= argc_d;   rd_q   <= rd_d;    cnt_q  <= cnt_d;   ridx_q  <= ridx_d;
      tmo_q   <= tmo_d;    err_q  <= err_d;   ovf_q  <= ovf_d;   tflag_q <= tflag_d;
      invol_q <= invol_d;  rr_q   <= rr_d;
      in_ready_q <= in_ready_d;  out_valid_q <= out_valid_d;  out_data_q <= out_data_d;
      arg_data_q <= arg_data_d;  cmd_q <= cmd_d;  cmd_ready_q <= cmd_ready_d;
      invol_grant_q <= invol_grant_d;
    end
  end

  // Buffer contents need no reset: counters define what is valid
  always_ff @(posedge clk) begin
    if (arg_we)  arg_buf_q[AW'(argc_q)] <= in_data;
    if (resp_we) resp_buf_q[RIW'(cnt_q)] <= resp_wdata;
  end

endmodule
